// File: rtl/lm07_spi_ctrl_if.sv
// lm07_spi_ctrl_if: host-side request/result bundle for lm07_spi_ctrl
// master = display/debug logic, slave = lm07_spi_ctrl; LM07_ALARM_EN adds thresh/alarm
interface lm07_spi_ctrl_if;
  logic req;
  logic poll_en;
  logic busy;
  logic data_valid;
  logic [15:0] data;
  logic [8:0] temp_c;
`ifdef LM07_ALARM_EN
  logic [8:0] thresh;
  logic alarm;
  modport master(output req, poll_en, thresh, input busy, data, temp_c, data_valid, alarm);
  modport slave(input req, poll_en, thresh, output busy, data, temp_c, data_valid, alarm);
`else
  modport master(output req, poll_en, input busy, data, temp_c, data_valid);
  modport slave(input req, poll_en, output busy, data, temp_c, data_valid);
`endif
endinterface

// File: rtl/lm07_spi_ctrl.sv
// lm07_spi_ctrl: LM07 SPI master with manual and periodic read scheduling
// Ports: SYSCLK, RSTN (sync, active low); bus = host side (req, poll_en, busy, data,
// temp_c, data_valid); CS/SCK/SIO = sensor pins. LM07_ALARM_EN adds bus.thresh/bus.alarm.
module lm07_spi_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int NBITS = 16,
  parameter int POLL_PERIOD = 1000,
  parameter int GAP_CYC = 8
) (
  input  logic SYSCLK,
  input  logic RSTN,
  lm07_spi_ctrl_if.slave bus,
  output logic CS,
  output logic SCK,
  input  logic SIO
);
  localparam logic [2:0] IDLE = 3'd0, SETUP = 3'd1, SCK_HI = 3'd2, SCK_LO = 3'd3, HOLD = 3'd4, GAP = 3'd5;
  localparam int PW = $clog2((CLK_DIV > GAP_CYC ? CLK_DIV : GAP_CYC) + 1);
  localparam int BW = $clog2(NBITS + 1);
  localparam int TW = $clog2(POLL_PERIOD + 1);
  logic [2:0] state;
  logic [PW-1:0] ph;
  logic [BW-1:0] bits;
  logic [TW-1:0] poll_cnt;
  logic [15:0] sh, data;
  logic pending, busy, data_valid, poll_fire, req_any, last, last_bit;
  assign poll_fire = bus.poll_en && poll_cnt == TW'(POLL_PERIOD - 1);
  assign req_any = bus.req || poll_fire;
  // GAP is timed by GAP_CYC, every other timed state by CLK_DIV
  assign last = ph == PW'(state == GAP ? GAP_CYC - 1 : CLK_DIV - 1);
  assign last_bit = bits == BW'(NBITS - 1);
  assign bus.busy = busy;
  assign bus.data = data;
  assign bus.temp_c = data[15:7];
  assign bus.data_valid = data_valid;
  always_ff @(posedge SYSCLK) begin
    if (!RSTN) begin
      state <= IDLE;
      ph <= '0;
      bits <= '0;
      poll_cnt <= '0;
      sh <= '0;
      data <= '0;
      pending <= 1'b0;
      busy <= 1'b0;
      data_valid <= 1'b0;
      CS <= 1'b1;
      SCK <= 1'b0;
    end else begin
      poll_cnt <= (!bus.poll_en || poll_fire) ? '0 : poll_cnt + 1'b1;
      data_valid <= 1'b0;
      ph <= (state == IDLE || last) ? '0 : ph + 1'b1;
      if (state != IDLE && req_any) pending <= 1'b1;
      case (state)
        IDLE: if (req_any || pending) begin
          state <= SETUP;
          CS <= 1'b0;
          busy <= 1'b1;
          pending <= 1'b0;
          bits <= '0;
        end
        SETUP: if (last) begin
          state <= SCK_HI;
          SCK <= 1'b1;
        end
        SCK_HI: if (last) begin
          sh <= {sh[14:0], SIO};
          state <= SCK_LO;
          SCK <= 1'b0;
        end
        SCK_LO: if (last) begin
          bits <= bits + 1'b1;
          state <= last_bit ? HOLD : SCK_HI;
          SCK <= !last_bit;
        end
        HOLD: if (last) begin
          state <= GAP;
          CS <= 1'b1;
          data <= sh;
          data_valid <= 1'b1;
        end
        GAP: if (last) begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef LM07_ALARM_EN
  logic alarm;
  always_ff @(posedge SYSCLK) begin
    if (!RSTN) alarm <= 1'b0;
    else if (state == HOLD && last) alarm <= $signed(sh[15:7]) > $signed(bus.thresh);
  end
  assign bus.alarm = alarm;
`endif
endmodule

// File: tb/tb_lm07_spi_ctrl.sv
// tb_lm07_spi_ctrl: table-driven and scoreboard checks for lm07_spi_ctrl
module tb_lm07_spi_ctrl;
  typedef struct packed { logic [15:0] d; logic [8:0] t; } exp_t;
  typedef struct { logic [15:0] w; logic [15:0] d; logic [8:0] t; } vec_t;
  logic SYSCLK = 1'b0, RSTN = 1'b0, CS, SCK, SIO;
  logic [15:0] sensor = 16'h0000;
  logic sck_q = 1'b0, cs_p = 1'b1, sck_p = 1'b0, abort = 1'b0;
  int cyc = 0, idx = 0, checks = 0, failures = 0;
  int cs_low = 0, cs_high = 0, rises = 0;
  exp_t exp_q[$];
  exp_t e;
  int vt[$], ft[$];
  vec_t vecs[8];
  lm07_spi_ctrl_if bus();
  lm07_spi_ctrl #(.CLK_DIV(4), .NBITS(16), .POLL_PERIOD(300), .GAP_CYC(8)) dut (
    .SYSCLK(SYSCLK), .RSTN(RSTN), .bus(bus), .CS(CS), .SCK(SCK), .SIO(SIO));
  always #5 SYSCLK = ~SYSCLK;
  always @(posedge SYSCLK) cyc <= cyc + 1;
  always @(posedge SYSCLK) begin
    if (CS !== 1'b0) idx <= 0;
    else if (sck_q && !SCK) idx <= idx + 1;
    sck_q <= SCK;
  end
  assign SIO = (idx < 16) ? sensor[4'(15 - idx)] : 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge SYSCLK) begin
    if (bus.data_valid === 1'b1) begin
      vt.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("data", bus.data, e.d);
        chk("temp_c", bus.temp_c, e.t);
      end
    end
    if (CS === 1'b1) begin
      if (cs_p === 1'b0) begin
        if (!abort) begin
          chk("cs_low_len", cs_low, 136);
          chk("sck_rises", rises, 16);
        end
        cs_low = 0;
        rises = 0;
      end
      cs_high++;
    end else if (CS === 1'b0) begin
      if (cs_p === 1'b1) begin
        ft.push_back(cyc);
        chk("cs_gap", cs_high >= 8, 1);
      end
      cs_high = 0;
      cs_low++;
      if (SCK === 1'b1 && sck_p === 1'b0) rises++;
    end
    cs_p = CS;
    sck_p = SCK;
  end
  task automatic go(input int t);
    while (cyc < t) begin
      @(posedge SYSCLK);
      #1;
    end
  endtask
  task automatic pulse_req();
    bus.req = 1'b1;
    @(posedge SYSCLK);
    #1;
    bus.req = 1'b0;
  endtask
  task automatic wait_valid(input int t);
    int n = 0;
    while (bus.data_valid !== 1'b1 && n < 400) begin
      @(negedge SYSCLK);
      n++;
    end
    chk("valid_cycle", bus.data_valid === 1'b1 ? cyc : -1, t);
  endtask
  task automatic wait_idle(input int t);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 400) begin
      @(negedge SYSCLK);
      n++;
    end
    chk("busy_drop_cycle", bus.busy === 1'b0 ? cyc : -1, t);
  endtask
  task automatic do_read(input logic [15:0] w, input logic [15:0] d, input logic [8:0] t);
    int t0;
    sensor = w;
    exp_q.push_back(exp_t'{d, t});
    t0 = cyc;
    pulse_req();
    wait_valid(t0 + 137);
    wait_idle(t0 + 145);
    @(posedge SYSCLK);
    #1;
  endtask
  initial begin
    int q, t0, n0;
    vecs[0] = '{16'h0F00, 16'h0F00, 9'h01E};
    vecs[1] = '{16'hFF80, 16'hFF80, 9'h1FF};
    vecs[2] = '{16'h0000, 16'h0000, 9'h000};
    vecs[3] = '{16'h7FFF, 16'h7FFF, 9'h0FF};
    vecs[4] = '{16'h8000, 16'h8000, 9'h100};
    vecs[5] = '{16'h1234, 16'h1234, 9'h024};
    vecs[6] = '{16'hC97F, 16'hC97F, 9'h192};
    vecs[7] = '{16'h0080, 16'h0080, 9'h001};
    bus.req = 1'b0;
    bus.poll_en = 1'b0;
`ifdef LM07_ALARM_EN
    bus.thresh = 9'd0;
`endif
    repeat (3) @(posedge SYSCLK);
    #1;
    chk("rst_cs", CS, 1);
    chk("rst_sck", SCK, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_data", bus.data, 0);
    chk("rst_temp", bus.temp_c, 0);
    chk("rst_valid", bus.data_valid, 0);
`ifdef LM07_ALARM_EN
    chk("rst_alarm", bus.alarm, 0);
`endif
    RSTN = 1'b1;
    go(cyc + 10);
    for (int i = 0; i < 8; i++) do_read(vecs[i].w, vecs[i].d, vecs[i].t);
    sensor = 16'h0F00;
    for (int i = 0; i < 3; i++) exp_q.push_back(exp_t'{16'h0F00, 9'h01E});
    vt.delete();
    q = cyc;
    bus.poll_en = 1'b1;
    go(q + 1150);
    bus.poll_en = 1'b0;
    chk("poll_count", vt.size(), 3);
    chk("poll_first", vt.size() > 0 ? vt[0] : -1, q + 436);
    chk("poll_space1", vt.size() > 1 ? vt[1] - vt[0] : -1, 300);
    chk("poll_space2", vt.size() > 2 ? vt[2] - vt[1] : -1, 300);
    go(cyc + 5);
    vt.delete();
    sensor = 16'h1234;
    exp_q.push_back(exp_t'{16'h1234, 9'h024});
    exp_q.push_back(exp_t'{16'h0F00, 9'h01E});
    q = cyc;
    bus.poll_en = 1'b1;
    go(q + 239);
    t0 = cyc;
    pulse_req();
    go(t0 + 50);
    pulse_req();
    go(t0 + 140);
    sensor = 16'h0F00;
    go(t0 + 200);
    bus.poll_en = 1'b0;
    go(t0 + 420);
    chk("coll_count", vt.size(), 2);
    chk("coll_valid1", vt.size() > 0 ? vt[0] : -1, t0 + 137);
    chk("coll_valid2", vt.size() > 1 ? vt[1] : -1, t0 + 282);
    chk("coll_cs_fall", ft.size() > 0 ? ft[ft.size() - 1] : -1, t0 + 146);
    sensor = 16'hABCD;
    abort = 1'b1;
    n0 = vt.size();
    t0 = cyc;
    pulse_req();
    go(t0 + 62);
    RSTN = 1'b0;
    @(posedge SYSCLK);
    #1;
    RSTN = 1'b1;
    chk("abort_rises", rises, 8);
    chk("abort_cs", CS, 1);
    chk("abort_sck", SCK, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_data", bus.data, 0);
    go(cyc + 200);
    chk("abort_no_valid", vt.size(), n0);
    chk("abort_data_kept", bus.data, 0);
    abort = 1'b0;
    do_read(16'h0F00, 16'h0F00, 9'h01E);
`ifdef LM07_ALARM_EN
    bus.thresh = 9'd29;
    do_read(16'h0F00, 16'h0F00, 9'h01E);
    chk("alarm_29", bus.alarm, 1);
    bus.thresh = 9'd30;
    do_read(16'h0F00, 16'h0F00, 9'h01E);
    chk("alarm_30", bus.alarm, 0);
    bus.thresh = 9'h1FE;
    do_read(16'hFF80, 16'hFF80, 9'h1FF);
    chk("alarm_neg", bus.alarm, 1);
`endif
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
